// File: rtl/fact_pkg.sv
// Shared types and helpers for the iterative factorial engine.
// Holds the FSM state encoding and the done-latency formula.
package fact_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        MULT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Edges from the accepting edge to done_o rising (no early exit).
    function automatic int fact_latency(input int x);
        return (x > 1) ? 2 + 2 * (x - 1) : 2;
    endfunction

endpackage

// File: rtl/factorial_engine_if.sv
// Request/completion bundle between a requester and factorial_engine.
// master drives requests and acks; slave is the engine.
interface factorial_engine_if #(
    parameter int W  = 32,
    parameter int XW = 6
);
    logic          start_i;
    logic [XW-1:0] x_i;
    logic          abort_i;
    logic          ack_i;
    logic          ready_o;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  result_o;
    logic          overflow_o;

    modport master (
        output start_i, x_i, abort_i, ack_i,
        input  ready_o, busy_o, done_o,
        input  result_o, overflow_o
    );

    modport slave (
        input  start_i, x_i, abort_i, ack_i,
        output ready_o, busy_o, done_o,
        output result_o, overflow_o
    );
endinterface

// File: rtl/fact_mul_chk.sv
// Combinational W x XW multiply, truncated to W bits.
// ovf flags any nonzero bit above the W-bit result.
module fact_mul_chk #(
    parameter int W  = 32,
    parameter int XW = 6
) (
    input  logic [W-1:0]  a,
    input  logic [XW-1:0] b,
    output logic [W-1:0]  p,
    output logic          ovf
);
    logic [W+XW-1:0] full;

    assign full = {{XW{1'b0}}, a} * {{W{1'b0}}, b};
    assign p    = full[W-1:0];
    assign ovf  = |full[W+XW-1:W];
endmodule

// File: rtl/factorial_engine.sv
// Iterative x! engine: start/ready request, done/ack completion, abort.
// FACT_EARLY_EXIT_EN: on first overflow, saturate and finish at once.
module factorial_engine
    import fact_pkg::*;
#(
    parameter int W  = 32,
    parameter int XW = 6
) (
    input logic CLK,
    input logic RST_N,
    factorial_engine_if.slave bus
);
    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  result_q;
    logic [W-1:0]  prod;
    logic [XW-1:0] i_q;
    logic [XW-1:0] x_q;
    logic [XW-1:0] i_nx;
    logic          ovf_q;
    logic          overflow_q;
    logic          prod_ovf;
    logic          abort_op;

    assign i_nx     = i_q + 1'b1;
    assign abort_op = bus.abort_i && (state_q != IDLE);

    fact_mul_chk #(.W(W), .XW(XW)) u_mul (
        .a   (acc_q),
        .b   (i_nx),
        .p   (prod),
        .ovf (prod_ovf)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; abort of a live operation overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.start_i && !bus.abort_i) state_d = LOAD;
            LOAD:  state_d = CHECK;
            CHECK: state_d = (i_q < x_q) ? MULT : DONE;
`ifdef FACT_EARLY_EXIT_EN
            MULT:  state_d = prod_ovf ? DONE : CHECK;
`else
            MULT:  state_d = CHECK;
`endif
            DONE:  if (bus.ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_op) state_d = IDLE;
    end

    // Datapath: operand capture, accumulate, and result publish.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q      <= W'(1);
            i_q        <= XW'(1);
            x_q        <= '0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else if (!abort_op) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i && !bus.abort_i) x_q <= bus.x_i;
                end
                LOAD: begin
                    acc_q <= W'(1);
                    i_q   <= XW'(1);
                    ovf_q <= 1'b0;
                end
                CHECK: begin
                    if (!(i_q < x_q)) begin
                        result_q   <= acc_q;
                        overflow_q <= ovf_q;
                    end
                end
                MULT: begin
                    i_q   <= i_nx;
                    acc_q <= prod;
                    ovf_q <= ovf_q | prod_ovf;
`ifdef FACT_EARLY_EXIT_EN
                    if (prod_ovf) begin
                        result_q   <= '1;
                        overflow_q <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o    = (state_q == IDLE);
    assign bus.busy_o     = (state_q == LOAD) || (state_q == CHECK) ||
                            (state_q == MULT);
    assign bus.done_o     = (state_q == DONE);
    assign bus.result_o   = result_q;
    assign bus.overflow_o = overflow_q;
endmodule
